// File: rtl/rubiks_pkg.sv
// Shared types and defaults for the cube frame scheduler.
// Color codes are the 3-bit sticker values carried in each orientation word.
package rubiks_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BLANK,
    S_WAIT_DONE,
    S_GAP
  } sched_state_t;

  localparam logic [2:0] RED       = 3'd0;
  localparam logic [2:0] ORANGE    = 3'd1;
  localparam logic [2:0] YELLOW    = 3'd2;
  localparam logic [2:0] GREEN     = 3'd3;
  localparam logic [2:0] BLUE      = 3'd4;
  localparam logic [2:0] PURPLE    = 3'd5;
  localparam logic [2:0] MAX_COLOR = PURPLE;

  localparam int NUM_FIELDS = 9;

  localparam int GAP_DEFAULT     = 2000;
  localparam int REFRESH_DEFAULT = 4000000;
  localparam int TIMEOUT_DEFAULT = 400000;

endpackage

// File: rtl/orientation_check.sv
// Combinational validator for an incoming orientation word.
// A word is good when the reserved bits are clear and every sticker is a real color.
import rubiks_pkg::*;

module orientation_check (
  input  logic [31:0] word,
  output logic        ok
);

  always_comb begin
    ok = (word[31:27] == 5'd0);
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (word[3*k +: 3] > MAX_COLOR) begin
        ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Schedules orientation frames to the LED core: load pulse, blanking,
// completion wait with timeout, inter-frame gap and periodic refresh.
import rubiks_pkg::*;

module frame_scheduler #(
  parameter int GAP_CYCLES     = GAP_DEFAULT,
  parameter int REFRESH_CYCLES = REFRESH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        word_valid,
  input  logic [31:0] word,
  input  logic        finished,
  output logic        load,
  output logic [31:0] orientation,
  output logic        busy,
  output logic        err_invalid,
  output logic        err_timeout,
  output logic [7:0]  drop_count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  sched_state_t state, next;

  logic          word_ok;
  logic          accept;
  logic          reject;
  logic          take;
  logic          refresh_due;
  logic          tmo_hit;
  logic          pending;
  logic          have_frame;
  logic [31:0]   pend_buf;
  logic          blank_cnt;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] refresh_cnt;
  logic [TW-1:0] tmo_cnt;

  orientation_check u_check (
    .word (word),
    .ok   (word_ok)
  );

  assign accept      = word_valid & word_ok;
  assign reject      = word_valid & ~word_ok;
  assign refresh_due = have_frame & (refresh_cnt == REF_LAST);
  assign tmo_hit     = (tmo_cnt == TMO_LAST);

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:      if (pending || refresh_due) next = S_LOAD;
      S_LOAD:      next = S_BLANK;
      S_BLANK:     if (blank_cnt) next = S_WAIT_DONE;
      S_WAIT_DONE: if (finished || tmo_hit) next = S_GAP;
      S_GAP:       if (gap_cnt == GAP_LAST) next = S_IDLE;
      default:     next = S_IDLE;
    endcase
  end

  assign take = (state == S_IDLE) & (next == S_LOAD);
  assign load = (state == S_LOAD) & ~reset;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      orientation <= 32'h0;
      pend_buf    <= 32'h0;
      pending     <= 1'b0;
      have_frame  <= 1'b0;
      err_invalid <= 1'b0;
      err_timeout <= 1'b0;
      drop_count  <= 8'd0;
      blank_cnt   <= 1'b0;
      gap_cnt     <= '0;
      refresh_cnt <= '0;
      tmo_cnt     <= '0;
    end else begin
      state     <= next;
      blank_cnt <= (state == S_BLANK) ? ~blank_cnt : 1'b0;

      if (next != state)
        tmo_cnt <= '0;
      else if (state == S_WAIT_DONE)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (next != state)
        gap_cnt <= '0;
      else if (state == S_GAP)
        gap_cnt <= gap_cnt + 1'b1;

      // Cleared on LOAD entry so the next refresh lands REFRESH_CYCLES after load
      if (take)
        refresh_cnt <= '0;
      else if (refresh_cnt != REF_LAST)
        refresh_cnt <= refresh_cnt + 1'b1;

      if (take) begin
        if (pending)
          orientation <= pend_buf;
        have_frame <= 1'b1;
      end

      if (accept) begin
        pend_buf <= word;
        pending  <= 1'b1;
        if (pending && !take && drop_count != 8'hff)
          drop_count <= drop_count + 8'd1;
      end else if (take) begin
        pending <= 1'b0;
      end

      if (reject)
        err_invalid <= 1'b1;

      if (state == S_WAIT_DONE && !finished && tmo_hit)
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios plus random traffic,
// every cycle compared against a frame-timeline reference model.
module tb_frame_scheduler;

  localparam int GAP = 8;
  localparam int REF = 100;
  localparam int TMO = 50;

  logic        clk;
  logic        reset;
  logic        word_valid;
  logic [31:0] word;
  logic        finished;
  logic        load;
  logic [31:0] orientation;
  logic        busy;
  logic        err_invalid;
  logic        err_timeout;
  logic [7:0]  drop_count;

  frame_scheduler #(
    .GAP_CYCLES     (GAP),
    .REFRESH_CYCLES (REF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .word_valid  (word_valid),
    .word        (word),
    .finished    (finished),
    .load        (load),
    .orientation (orientation),
    .busy        (busy),
    .err_invalid (err_invalid),
    .err_timeout (err_timeout),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a timeline indexed by k = cycles since load
  bit          m_in_frame;
  int          m_k;
  int          m_done;
  bit          m_pending;
  logic [31:0] m_pbuf;
  logic [31:0] m_orient;
  bit          m_have;
  int          m_age;
  int          m_drops;
  bit          m_einv;
  bit          m_eto;

  function automatic bit word_good(input logic [31:0] w);
    if ((w >> 27) != 0) return 1'b0;
    for (int i = 0; i < 9; i++)
      if (((w >> (3 * i)) & 32'd7) > 32'd5) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_in_frame = 0; m_k = 0; m_done = -1;
    m_pending = 0; m_pbuf = 0; m_orient = 0; m_have = 0;
    m_age = 0; m_drops = 0; m_einv = 0; m_eto = 0;
  endtask

  task automatic model_step(input bit r, input bit v,
                            input logic [31:0] w, input bit f);
    bit take;
    bit oldp;
    if (r) begin
      m_reset();
      return;
    end
    oldp = m_pending;
    take = 0;
    if (m_in_frame) begin
      if (m_k >= 3 && m_done < 0) begin
        if (f) m_done = m_k;
        else if (m_k - 3 == TMO - 1) begin
          m_done = m_k;
          m_eto  = 1;
        end
      end
      m_k++;
      if (m_done >= 0 && m_k > m_done + GAP) m_in_frame = 0;
    end else if (m_pending || (m_have && m_age == REF - 1)) begin
      take = 1;
      m_in_frame = 1; m_k = 0; m_done = -1;
      if (m_pending) m_orient = m_pbuf;
      m_pending = 0;
      m_have = 1;
    end
    if (take) m_age = 0;
    else if (m_age < REF - 1) m_age++;
    if (v) begin
      if (word_good(w)) begin
        if (oldp && !take && m_drops < 255) m_drops++;
        m_pbuf = w;
        m_pending = 1;
      end else begin
        m_einv = 1;
      end
    end
  endtask

  int ncyc = 0;
  int load_q[$];
  int to_cyc;
  int fall_cyc;
  bit prev_busy;

  task automatic clr_track();
    load_q.delete();
    to_cyc = -1;
    fall_cyc = -1;
    prev_busy = busy;
  endtask

  // One clock cycle: drive at negedge, compare, advance the model
  task automatic tick(input bit r, input bit v, input logic [31:0] w,
                      input bit f);
    reset = r; word_valid = v; word = w; finished = f;
    #1;
    check("load", load, m_in_frame && m_k == 0 && !r);
    check("busy", busy, m_in_frame);
    check("orientation", orientation, m_orient);
    check("err_invalid", err_invalid, m_einv);
    check("err_timeout", err_timeout, m_eto);
    check("drop_count", drop_count, m_drops);
    if (load) load_q.push_back(ncyc);
    if (err_timeout && to_cyc < 0) to_cyc = ncyc;
    if (prev_busy && !busy) fall_cyc = ncyc;
    prev_busy = busy;
    model_step(r, v, w, f);
    ncyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit f);
    repeat (n) tick(0, 0, 32'h0, f);
  endtask

  function automatic logic [31:0] rand_valid();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 9; i++) w[3*i +: 3] = 3'($urandom_range(0, 5));
    return w;
  endfunction

  task automatic do_reset();
    tick(1, 1, rand_valid(), 0);
    tick(1, 1, rand_valid(), 0);
    tick(0, 0, 32'h0, 0);
  endtask

  int t;
  logic [31:0] wa, wb, wc, wd;
  int bias;

  initial begin
    reset = 1'b1; word_valid = 1'b0; word = 32'h0; finished = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_reset();
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_orient", orientation, 32'h0);
    check("rst_drops", drop_count, 0);
    check("rst_errs", {err_invalid, err_timeout}, 0);

    // Basic frame timing
    clr_track();
    t = ncyc;
    tick(0, 1, 32'h0222C688, 0);
    idle(5, 0);
    tick(0, 0, 32'h0, 1);
    idle(15, 0);
    check("r031_nloads", load_q.size(), 1);
    if (load_q.size() > 0) check("r031_load_at", load_q[0] - t, 2);
    check("r031_busy_fall", fall_cyc - t, 15);
    check("r031_orient", orientation, 32'h0222C688);

    // Rejected words
    do_reset();
    clr_track();
    tick(0, 1, 32'h00000006, 0);
    tick(0, 1, 32'h80000000, 0);
    idle(20, 0);
    check("r032_nloads", load_q.size(), 0);
    check("r032_err_inv", err_invalid, 1);
    check("r032_orient", orientation, 32'h0);

    // Overwrites during WAIT_DONE
    do_reset();
    clr_track();
    wa = rand_valid(); wb = rand_valid();
    wc = rand_valid(); wd = rand_valid();
    tick(0, 1, wa, 0);
    idle(6, 0);
    tick(0, 1, wb, 0);
    tick(0, 1, wc, 0);
    tick(0, 1, wd, 0);
    tick(0, 0, 32'h0, 1);
    idle(30, 0);
    check("r033_drops", drop_count, 2);
    check("r033_nloads", load_q.size(), 2);
    check("r033_orient", orientation, wd);

    // Timeout
    do_reset();
    clr_track();
    tick(0, 1, wa, 0);
    idle(80, 0);
    check("r034_err_to", err_timeout, 1);
    if (load_q.size() > 0) begin
      check("r034_to_delay", to_cyc - load_q[0], 53);
      check("r034_idle_at", fall_cyc - load_q[0], 61);
    end else begin
      check("r034_nloads", load_q.size(), 1);
    end
    check("r034_busy", busy, 0);

    // Refresh
    do_reset();
    clr_track();
    tick(0, 1, wb, 0);
    idle(120, 1);
    check("r035_nloads", load_q.size(), 2);
    if (load_q.size() >= 2)
      check("r035_period", load_q[1] - load_q[0], 100);
    check("r035_orient", orientation, wb);

    // Reset mid-frame
    do_reset();
    clr_track();
    tick(0, 1, wc, 0);
    idle(6, 0);
    tick(1, 1, rand_valid(), 0);
    check("r036_busy", busy, 0);
    check("r036_orient", orientation, 32'h0);
    check("r036_load", load, 0);
    idle(250, 1);
    check("r036_nloads", load_q.size(), 1);

    // Random traffic
    do_reset();
    bias = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: bias = 0;
          1: bias = 5;
          default: bias = 60;
        endcase
      end
      tick($urandom_range(0, 799) == 0,
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 4) == 0) ? $urandom : rand_valid(),
           $urandom_range(0, 99) < bias);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
